sync_fifo_mc: RTL

SYNC_FIFO_MC -- requirements
Module: sync_fifo_mc

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ch_ctrl.sv | 83 ++++++++
 rtl/sync_fifo_mc.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the multi-channel synchronous FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } ch_flags_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of channel ch inside the packed fill_level bus.
  function automatic int lvl_lsb(input int ch, input int ptr_w);
    return ch * (ptr_w + 1);
  endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel pointers, level, status and sticky errors; flags are decoded from registered pointers.
// Writes to a full channel and reads from an empty one are refused and latched as overflow/underflow.
module fifo_ch_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AF    = 6,
  parameter int AE    = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req_i,
  input  logic             rd_req_i,
  input  logic             clr_err_i,
  output logic             wr_ok_o,
  output logic             rd_ok_o,
  output logic [PTR_W-1:0] waddr_o,
  output logic [PTR_W-1:0] raddr_o,
  output logic [LVL_W-1:0] level_o,
  output ch_flags_t        flags_o
);

  logic [LVL_W-1:0] wptr_q, wptr_d;
  logic [LVL_W-1:0] rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;

  // Extra pointer MSB separates full (level == DEPTH) from empty (level == 0).
  assign level = wptr_q - rptr_q;
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  assign wr_ok_o = wr_req_i && !full;
  assign rd_ok_o = rd_req_i && !empty;
  assign waddr_o = wptr_q[PTR_W-1:0];
  assign raddr_o = rptr_q[PTR_W-1:0];
  assign level_o = level;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (wr_ok_o) wptr_d = wptr_q + LVL_W'(1);
    if (rd_ok_o) rptr_d = rptr_q + LVL_W'(1);
    // A new error in the clearing cycle must not be lost.
    if (clr_err_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_req_i && full)  ovf_d = 1'b1;
    if (rd_req_i && empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  always_comb begin
    flags_o.full   = full;
    flags_o.empty  = empty;
    flags_o.afull  = (level >= LVL_W'(AF));
    flags_o.aempty = (level <= LVL_W'(AE));
    flags_o.ovf    = ovf_q;
    flags_o.udf    = udf_q;
  end

endmodule

// File: rtl/sync_fifo_mc.sv
// NUM_CH independent FIFOs sharing one storage array; read data is registered, valid one cycle after rd_en.
// No stall path: refused requests are dropped and flagged per channel via overflow/underflow.
module sync_fifo_mc
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2,
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [CH_W-1:0]                   wr_ch,
  input  logic [FIFO_WIDTH-1:0]             data_in,
  input  logic                              rd_en,
  input  logic [CH_W-1:0]                   rd_ch,
  input  logic                              clr_err,
  output logic [FIFO_WIDTH-1:0]             data_out,
  output logic                              rd_valid,
  output logic [NUM_CH-1:0]                 fifo_full,
  output logic [NUM_CH-1:0]                 fifo_empty,
  output logic [NUM_CH-1:0]                 almost_full,
  output logic [NUM_CH-1:0]                 almost_empty,
  output logic [NUM_CH*(PTR_WIDTH+1)-1:0]   fill_level,
  output logic [NUM_CH-1:0]                 overflow,
  output logic [NUM_CH-1:0]                 underflow
);

  localparam int LVL_W     = PTR_WIDTH + 1;
  localparam int ADDR_W    = CH_W + PTR_WIDTH;
  localparam int MEM_DEPTH = NUM_CH * FIFO_DEPTH;

  logic [NUM_CH-1:0]                 wr_ok;
  logic [NUM_CH-1:0]                 rd_ok;
  logic [NUM_CH-1:0][PTR_WIDTH-1:0]  ch_waddr;
  logic [NUM_CH-1:0][PTR_WIDTH-1:0]  ch_raddr;
  ch_flags_t [NUM_CH-1:0]            ch_flags;
  logic [ADDR_W-1:0]                 waddr;
  logic [ADDR_W-1:0]                 raddr;
  logic [FIFO_WIDTH-1:0]             mem [MEM_DEPTH];
  logic [FIFO_WIDTH-1:0]             data_out_q, data_out_d;
  logic                              rd_valid_q, rd_valid_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_ch_ctrl #(
      .DEPTH (FIFO_DEPTH),
      .AF    (AF_THRESH),
      .AE    (AE_THRESH)
    ) u_ctrl (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_req_i  (wr_en && (wr_ch == CH_W'(c))),
      .rd_req_i  (rd_en && (rd_ch == CH_W'(c))),
      .clr_err_i (clr_err),
      .wr_ok_o   (wr_ok[c]),
      .rd_ok_o   (rd_ok[c]),
      .waddr_o   (ch_waddr[c]),
      .raddr_o   (ch_raddr[c]),
      .level_o   (fill_level[lvl_lsb(c, PTR_WIDTH) +: LVL_W]),
      .flags_o   (ch_flags[c])
    );

    assign fifo_full[c]    = ch_flags[c].full;
    assign fifo_empty[c]   = ch_flags[c].empty;
    assign almost_full[c]  = ch_flags[c].afull;
    assign almost_empty[c] = ch_flags[c].aempty;
    assign overflow[c]     = ch_flags[c].ovf;
    assign underflow[c]    = ch_flags[c].udf;
  end

  // At most one channel is selected per side, so the accepted one owns the address.
  always_comb begin
    waddr = '0;
    raddr = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok[c]) waddr = {CH_W'(c), ch_waddr[c]};
      if (rd_ok[c]) raddr = {CH_W'(c), ch_raddr[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (|wr_ok) mem[waddr] <= data_in;
  end

  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = |rd_ok;
    if (|rd_ok) data_out_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule
